// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding the PC adder.
// Owns the architectural PC, runs a req/ack handshake with instruction
// memory and hands words to decode over valid/ready, with a one-entry
// skid buffer and a flush/redirect path.
// Optional build macro: FETCH_PERF_CNT_EN adds the stall_cnt output.
//
// state   | meaning
// IDLE    | no request; refetch starts next cycle
// FETCH   | request to pc_cur outstanding
// HOLD    | fetched word parked in skid, waiting for decode
// DISCARD | flushed while a request was open; wait for its ack and drop it
module fetch_unit #(
  parameter int              AW       = 12,
  parameter int              DW       = 16,
  parameter logic [AW-1:0]   RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [AW-1:0] pc_cur,
  input  logic [AW-1:0] pc_next,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [DW-1:0] imem_rdata,
  output logic          instr_valid,
  input  logic          instr_ready,
  output logic [DW-1:0] instr_data,
  output logic [AW-1:0] instr_pc,
`ifdef FETCH_PERF_CNT_EN
  output logic [15:0]   stall_cnt,
`endif
  input  logic          flush,
  input  logic [AW-1:0] flush_pc
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FETCH   = 2'd1,
    S_HOLD    = 2'd2,
    S_DISCARD = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q;
  logic [AW-1:0] addr_q;
  logic          valid_q;
  logic [DW-1:0] data_q;
  logic [AW-1:0] ipc_q;
  logic          skid_valid_q;
  logic [DW-1:0] skid_data_q;
  logic [AW-1:0] skid_pc_q;

  logic out_fire;
  logic can_accept;
  logic fetch_ack;
  logic skid_xfer;

  assign out_fire   = valid_q & instr_ready;
  assign can_accept = ~valid_q | instr_ready;
  assign fetch_ack  = (state_q == S_FETCH) & imem_ack;
  assign skid_xfer  = (state_q == S_HOLD) & skid_valid_q & out_fire;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; flush overrides ack, out_fire and skid transfer.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    state_d = flush ? S_IDLE : S_FETCH;
      S_FETCH: begin
        if (flush)         state_d = imem_ack ? S_IDLE : S_DISCARD;
        else if (imem_ack) state_d = can_accept ? S_IDLE : S_HOLD;
      end
      S_HOLD: begin
        if (flush || skid_xfer) state_d = S_IDLE;
      end
      // A flush here only retargets the PC; the open request still has to
      // be drained, and once its ack arrives the bus is free again.
      S_DISCARD: begin
        if (imem_ack) state_d = S_IDLE;
      end
      default:   state_d = S_IDLE;
    endcase
  end

  // Memory-side outputs; DISCARD keeps presenting the abandoned address
  // because pc_cur has already moved to the redirect target.
  always_comb begin
    imem_req  = 1'b0;
    imem_addr = pc_q;
    unique case (state_q)
      S_FETCH:   imem_req = 1'b1;
      S_DISCARD: begin
        imem_req  = 1'b1;
        imem_addr = addr_q;
      end
      default:   imem_req = 1'b0;
    endcase
  end

  // Architectural PC and the latched request address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q   <= RESET_PC;
      addr_q <= RESET_PC;
    end else begin
      if (state_q == S_FETCH) addr_q <= pc_q;
      if (flush)              pc_q   <= flush_pc;
      else if (fetch_ack)     pc_q   <= pc_next;
    end
  end

  // Decode-facing output register; a load beats the clear from out_fire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ipc_q   <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (fetch_ack && can_accept) begin
      valid_q <= 1'b1;
      data_q  <= imem_rdata;
      ipc_q   <= pc_q;
    end else if (skid_xfer) begin
      valid_q <= 1'b1;
      data_q  <= skid_data_q;
      ipc_q   <= skid_pc_q;
    end else if (out_fire) begin
      valid_q <= 1'b0;
    end
  end

  // Skid entry catches a word that arrives while decode is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_pc_q    <= '0;
    end else if (flush) begin
      skid_valid_q <= 1'b0;
    end else if (fetch_ack && !can_accept) begin
      skid_valid_q <= 1'b1;
      skid_data_q  <= imem_rdata;
      skid_pc_q    <= pc_q;
    end else if (skid_xfer) begin
      skid_valid_q <= 1'b0;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] stall_q;

  // Saturating count of cycles where decode back-pressure stalls fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (flush) begin
      stall_q <= '0;
    end else if (((state_q == S_HOLD) || (valid_q && !instr_ready)) &&
                 (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`endif

  assign pc_cur      = pc_q;
  assign instr_valid = valid_q;
  assign instr_data  = data_q;
  assign instr_pc    = ipc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit with a behavioural memory
// (word at address A reads as {4'hA, A}) and a +1 adder.
module tb_fetch_unit;

  localparam int AW = 12;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] pc_cur;
  logic [AW-1:0] pc_next;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack = 1'b0;
  logic [DW-1:0] imem_rdata = '0;
  logic          instr_valid;
  logic          instr_ready;
  logic [DW-1:0] instr_data;
  logic [AW-1:0] instr_pc;
  logic          flush;
  logic [AW-1:0] flush_pc;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0]   stall_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int mem_wait = 1;
  int age = 0;
  logic req_rise = 1'b0;
  logic [27:0] dq[$];

  always #5 clk = ~clk;

  assign pc_next = pc_cur + 12'd1;

  fetch_unit #(.AW(AW), .DW(DW), .RESET_PC(12'h000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc_cur      (pc_cur),
    .pc_next     (pc_next),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_data  (instr_data),
    .instr_pc    (instr_pc),
`ifdef FETCH_PERF_CNT_EN
    .stall_cnt   (stall_cnt),
`endif
    .flush       (flush),
    .flush_pc    (flush_pc)
  );

  // Memory model: ack after mem_wait cycles of a held request, never in the first.
  always @(negedge clk) begin
    if (!imem_req) begin
      age = 0;
      imem_ack = 1'b0;
    end else begin
      if (age >= mem_wait) begin
        imem_ack   = 1'b1;
        imem_rdata = {4'hA, imem_addr};
      end else begin
        imem_ack = 1'b0;
      end
      age++;
    end
  end

  // Record every word decode will accept at the coming edge.
  always @(negedge clk) begin
    if (rst_n && instr_valid && instr_ready && !flush)
      dq.push_back({instr_pc, instr_data});
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    logic prev;
    prev = imem_req;
    @(posedge clk);
    #1;
    req_rise = imem_req && !prev;
  endtask

  task automatic wait_req(input string tag, input logic [AW-1:0] a);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      if (req_rise && imem_addr == a) found = 1'b1;
      else cyc();
    end
    chk(tag, {31'd0, found}, 32'd1);
  endtask

  task automatic wait_q(input string tag, input int n);
    for (int i = 0; i < 60 && dq.size() < n; i++) cyc();
    chk(tag, {31'd0, dq.size() >= n}, 32'd1);
  endtask

  function automatic logic [27:0] qget(input int i);
    return (i < dq.size()) ? dq[i] : 28'hFFFFFFF;
  endfunction

  initial begin
    logic bad;
    rst_n = 1'b0;
    instr_ready = 1'b1;
    flush = 1'b0;
    flush_pc = '0;
    #22;
    chk("rst_pc", {20'd0, pc_cur}, 32'h000);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_data", {16'd0, instr_data}, 32'h0);
    chk("rst_ipc", {20'd0, instr_pc}, 32'h0);
    cyc();
    rst_n = 1'b1;

    // Straight-line fetch 000,001,002 with decode always ready
    wait_req("seq_req0", 12'h000);
    wait_req("seq_req1", 12'h001);
    wait_req("seq_req2", 12'h002);
    wait_q("seq_q", 3);
    chk("seq_w0", {4'd0, qget(0)}, 32'h000A000);
    chk("seq_w1", {4'd0, qget(1)}, 32'h001A001);
    chk("seq_w2", {4'd0, qget(2)}, 32'h002A002);
    chk("seq_pc3", {20'd0, pc_cur}, 32'h003);

    // Decode stalls 6 cycles: word 5 parks in skid, fetch idles in HOLD
    wait_req("stl_req4", 12'h004);
    dq.delete();
    instr_ready = 1'b0;
    for (int i = 0; i < 6; i++) cyc();
    chk("stl_req_low", {31'd0, imem_req}, 32'd0);
    chk("stl_valid", {31'd0, instr_valid}, 32'd1);
    chk("stl_ipc", {20'd0, instr_pc}, 32'h004);
    chk("stl_pc", {20'd0, pc_cur}, 32'h006);
`ifdef FETCH_PERF_CNT_EN
    chk("stl_cnt", {16'd0, stall_cnt}, 32'd4);
`endif
    instr_ready = 1'b1;
    wait_q("stl_q", 3);
    chk("stl_w0", {4'd0, qget(0)}, 32'h004A004);
    chk("stl_w1", {4'd0, qget(1)}, 32'h005A005);
    chk("stl_w2", {4'd0, qget(2)}, 32'h006A006);

    // Flush while the request to 005 is outstanding -> DISCARD
    mem_wait = 3;
    flush = 1'b1; flush_pc = 12'h005;
    cyc();
    flush = 1'b0;
    wait_req("dis_req5", 12'h005);
    flush = 1'b1; flush_pc = 12'h040;
    dq.delete();
    cyc();
    flush = 1'b0;
    chk("dis_req", {31'd0, imem_req}, 32'd1);
    chk("dis_addr", {20'd0, imem_addr}, 32'h005);
    chk("dis_pc", {20'd0, pc_cur}, 32'h040);
    bad = 1'b0;
    for (int i = 0; i < 60 && !(req_rise && imem_addr == 12'h040); i++) begin
      if (instr_valid) bad = 1'b1;
      cyc();
    end
    chk("dis_req40", {20'd0, imem_addr}, 32'h040);
    chk("dis_novalid", {31'd0, bad}, 32'd0);
    wait_q("dis_q", 1);
    chk("dis_w0", {4'd0, qget(0)}, 32'h040A040);

    // Flush coincident with ack and ready: flush wins
    mem_wait = 1;
    wait_req("fa_req41", 12'h041);
    cyc();
    flush = 1'b1; flush_pc = 12'h123; instr_ready = 1'b1;
    dq.delete();
    cyc();
    flush = 1'b0;
    chk("fa_valid", {31'd0, instr_valid}, 32'd0);
    chk("fa_pc", {20'd0, pc_cur}, 32'h123);
    chk("fa_req", {31'd0, imem_req}, 32'd0);
    wait_q("fa_q", 1);
    chk("fa_w0", {4'd0, qget(0)}, 32'h123A123);

    // PC wrap FFF -> 000 from the adder
    flush = 1'b1; flush_pc = 12'hFFF;
    cyc();
    flush = 1'b0;
    wait_req("wr_reqfff", 12'hFFF);
    dq.delete();
    wait_req("wr_req000", 12'h000);
    chk("wr_pc", {20'd0, pc_cur}, 32'h000);
    chk("wr_w0", {4'd0, qget(0)}, 32'hFFFAFFF);

    // Asynchronous reset in the middle of a fetch
    wait_req("ar_req1", 12'h001);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_req", {31'd0, imem_req}, 32'd0);
    chk("ar_pc", {20'd0, pc_cur}, 32'h000);
    chk("ar_valid", {31'd0, instr_valid}, 32'd0);
    cyc();
    cyc();
    rst_n = 1'b1;
    dq.delete();
    wait_req("ar_req0b", 12'h000);
    wait_req("ar_req1b", 12'h001);
    wait_q("ar_q", 2);
    chk("ar_w0", {4'd0, qget(0)}, 32'h000A000);
    chk("ar_w1", {4'd0, qget(1)}, 32'h001A001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
